uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_framer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: state encoding, default
// start-of-frame value and the word byte-select helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND_SOF,
        ST_SEND_DATA,
        ST_SEND_CSUM,
        ST_GAP
    } state_t;

    localparam logic [7:0]  DEFAULT_SOF_BYTE = 8'hA5;
    localparam int unsigned MAX_WORD_BYTES   = 16;
    localparam int unsigned FULL_W           = 8 * MAX_WORD_BYTES;
    localparam int unsigned IDX_W            = 4;

    // Byte idx of an nbytes-wide word (zero-extended to FULL_W), counted from
    // the most-significant end when msb_first is set.
    function automatic logic [7:0] byte_select(
        input logic [FULL_W-1:0] word,
        input int unsigned       nbytes,
        input int unsigned       idx,
        input logic              msb_first
    );
        int unsigned pos;
        pos = msb_first ? (nbytes - 1 - idx) : idx;
        return word[8*pos +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// Pops words from a source FIFO and hands them byte-by-byte to a UART core,
// optionally framed by a start-of-frame byte and a trailing XOR checksum.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 5,
    parameter bit          SOF_EN     = 1'b1,
    parameter logic [7:0]  SOF_BYTE   = DEFAULT_SOF_BYTE,
    parameter bit          CSUM_EN    = 1'b1,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Fifo_Empty,
    input  logic [8*WORD_BYTES-1:0]   Fifo_Read_Data,
    output logic                      Fifo_Read_Enable,
    input  logic                      UART_TX_Ready,
    output logic                      UART_TX_Enable,
    output logic [7:0]                UART_TX_Data,
    output logic                      Busy,
    output logic                      Diag_Valid,
    output logic [15:0]               Frame_Count
);

    localparam int unsigned     WW       = 8 * WORD_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    state_t            state, state_nxt;
    state_t            resume, resume_nxt;
    logic [WW-1:0]     word_q, word_nxt;
    logic [7:0]        csum_q, csum_nxt;
    logic [7:0]        data_q, data_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [15:0]       frame_cnt, frame_cnt_nxt;
    logic              fifo_re;
    logic              tx_en;
    logic              diag;
    logic              last_byte;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            resume    <= ST_IDLE;
            word_q    <= '0;
            csum_q    <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            resume    <= resume_nxt;
            word_q    <= word_nxt;
            csum_q    <= csum_nxt;
            data_q    <= data_nxt;
            idx_q     <= idx_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // The outgoing byte is registered one state ahead so it is already stable
    // when the strobe is allowed by Ready.
    always_comb begin
        state_nxt     = state;
        resume_nxt    = resume;
        word_nxt      = word_q;
        csum_nxt      = csum_q;
        data_nxt      = data_q;
        idx_nxt       = idx_q;
        frame_cnt_nxt = frame_cnt;
        fifo_re       = 1'b0;
        tx_en         = 1'b0;
        diag          = 1'b0;
        last_byte     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!Fifo_Empty) begin
                    fifo_re   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: state_nxt = ST_LATCH;

            ST_LATCH: begin
                word_nxt = Fifo_Read_Data;
                csum_nxt = '0;
                idx_nxt  = '0;
                if (SOF_EN) begin
                    data_nxt  = SOF_BYTE;
                    state_nxt = ST_SEND_SOF;
                end else begin
                    data_nxt  = byte_select(FULL_W'(Fifo_Read_Data), WORD_BYTES, 32'd0, MSB_FIRST);
                    state_nxt = ST_SEND_DATA;
                end
            end

            ST_SEND_SOF, ST_SEND_DATA, ST_SEND_CSUM: begin
                last_byte = (state == ST_SEND_CSUM) ||
                            ((state == ST_SEND_DATA) && (idx_q == LAST_IDX) && !CSUM_EN);
                if (UART_TX_Ready) begin
                    tx_en      = 1'b1;
                    resume_nxt = state;
                    state_nxt  = ST_GAP;
                    if (state == ST_SEND_DATA) begin
                        csum_nxt = csum_q ^ data_q;
                    end
                    if (last_byte) begin
                        diag          = 1'b1;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                    end
                end
            end

            ST_GAP: begin
                case (resume)
                    ST_SEND_SOF: begin
                        data_nxt  = byte_select(FULL_W'(word_q), WORD_BYTES, 32'd0, MSB_FIRST);
                        state_nxt = ST_SEND_DATA;
                    end
                    ST_SEND_DATA: begin
                        if (idx_q != LAST_IDX) begin
                            idx_nxt   = idx_q + 1'b1;
                            data_nxt  = byte_select(FULL_W'(word_q), WORD_BYTES,
                                                    32'(idx_q) + 32'd1, MSB_FIRST);
                            state_nxt = ST_SEND_DATA;
                        end else if (CSUM_EN) begin
                            data_nxt  = csum_q;
                            state_nxt = ST_SEND_CSUM;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read strobe is gated by Reset so it drops in the same cycle reset rises.
    assign Fifo_Read_Enable = fifo_re & ~Reset;
    assign UART_TX_Enable   = tx_en;
    assign UART_TX_Data     = data_q;
    assign Busy             = (state != ST_IDLE);
    assign Diag_Valid       = diag;
    assign Frame_Count      = frame_cnt;

endmodule
